// File: rtl/watchdog_ctrl.sv
// -----------------------------------------------------------------------------
// watchdog_ctrl
//
// Purpose:
//   Software watchdog with a programmable timeout and two kick requesters.
//   Once armed, a down-counter is loaded from the timeout register and
//   decrements every cycle.  A granted kick reloads the counter; if the
//   counter runs out the watchdog enters EXPIRED and raises a one-cycle
//   interrupt pulse.  EXPIRED is sticky until acknowledged with clear.
//
// Parameters:
//   CNT_WIDTH   - width of the timeout register and the down-counter
//   TIMEOUT_RST - timeout register value after reset (cycles)
//
// Ports:
//   ACLK        in   1          clock, all state changes on the rising edge
//   ARESET      in   1          synchronous reset, active-high
//   cfg_timeout in   CNT_WIDTH  new timeout value (cycles)
//   cfg_load    in   1          load cfg_timeout into the timeout register
//   arm         in   1          start request (honoured in IDLE only)
//   disarm      in   1          stop request (honoured in ARMED only)
//   clear       in   1          acknowledge expiry (honoured in EXPIRED only)
//   kick_req    in   2          per-requester kick request, level, held until acked
//   kick_ack    out  2          one-hot combinational kick grant
//   wd_active   out  1          registered, high while ARMED
//   wd_expired  out  1          registered, high while EXPIRED
//   wd_irq      out  1          registered, one-cycle pulse on entry to EXPIRED
//   count       out  CNT_WIDTH  remaining cycles before expiry
//   kick_cnt    out  16         accepted kicks since the last arm (wraps)
// -----------------------------------------------------------------------------
module watchdog_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT_RST = 1000
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [CNT_WIDTH-1:0] cfg_timeout,
  input  logic                 cfg_load,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 clear,
  input  logic [1:0]           kick_req,
  output logic [1:0]           kick_ack,
  output logic                 wd_active,
  output logic                 wd_expired,
  output logic                 wd_irq,
  output logic [CNT_WIDTH-1:0] count,
  output logic [15:0]          kick_cnt
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_RST_C = CNT_WIDTH'(TIMEOUT_RST);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO_C    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE_C     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_WIDTH-1:0]   timeout_r;
  logic [CNT_WIDTH-1:0]   count_r;
  logic [CNT_WIDTH-1:0]   count_nxt_s;
  logic [15:0]            kick_cnt_r;
  logic [15:0]            kick_cnt_nxt_s;
  // Requester that wins when both request at once (0 or 1).
  logic                   rr_pri_r;
  logic                   rr_pri_nxt_s;
  logic                   irq_nxt_s;
  logic                   active_r;
  logic                   expired_r;
  logic                   irq_r;
  logic [1:0]             grant_s;
  logic                   kick_acc_s;

  // Round-robin kick arbiter; grants only while ARMED and not being disarmed.
  always_comb begin
    grant_s = 2'b00;
    if (ARESET) begin
      grant_s = 2'b00;
    end else if ((state_r == ST_ARMED) && !disarm) begin
      case (kick_req)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = rr_pri_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign kick_acc_s = |grant_s;

  // Next-state, counter and round-robin update logic.
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    kick_cnt_nxt_s = kick_cnt_r;
    rr_pri_nxt_s   = rr_pri_r;
    irq_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The arm edge sees the timeout register before any same-edge load.
        if (arm && (timeout_r != CNT_ZERO_C)) begin
          state_nxt_s    = ST_ARMED;
          count_nxt_s    = timeout_r;
          kick_cnt_nxt_s = 16'd0;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_nxt_s    = ST_IDLE;
          count_nxt_s    = CNT_ZERO_C;
        end else if (kick_acc_s) begin
          // A kick wins over a simultaneous expiry.
          count_nxt_s    = timeout_r;
          kick_cnt_nxt_s = kick_cnt_r + 16'd1;
          // After serving requester 0 requester 1 gets priority, and back.
          rr_pri_nxt_s   = grant_s[0];
        end else if (count_r <= CNT_ONE_C) begin
          // count_r can only be 0 here if a zero timeout was reloaded by a
          // kick; treat it as immediate expiry rather than wrapping.
          state_nxt_s    = ST_EXPIRED;
          count_nxt_s    = CNT_ZERO_C;
          irq_nxt_s      = 1'b1;
        end else begin
          count_nxt_s    = count_r - CNT_ONE_C;
        end
      end
      ST_EXPIRED: begin
        if (clear) begin
          state_nxt_s    = ST_IDLE;
          count_nxt_s    = CNT_ZERO_C;
        end else begin
          state_nxt_s    = ST_EXPIRED;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        count_nxt_s      = CNT_ZERO_C;
      end
    endcase
  end

  // State, counter and status-flag registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r    <= ST_IDLE;
      count_r    <= CNT_ZERO_C;
      kick_cnt_r <= 16'd0;
      rr_pri_r   <= 1'b0;
      active_r   <= 1'b0;
      expired_r  <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      kick_cnt_r <= kick_cnt_nxt_s;
      rr_pri_r   <= rr_pri_nxt_s;
      // Flags are decoded from the next state so they are plain flops.
      active_r   <= (state_nxt_s == ST_ARMED);
      expired_r  <= (state_nxt_s == ST_EXPIRED);
      irq_r      <= irq_nxt_s;
    end
  end

  // Timeout register; a load while ARMED only affects the next reload.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      timeout_r <= TIMEOUT_RST_C;
    end else if (cfg_load) begin
      timeout_r <= cfg_timeout;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign kick_ack   = grant_s;
  assign wd_active  = active_r;
  assign wd_expired = expired_r;
  assign wd_irq     = irq_r;
  assign count      = count_r;
  assign kick_cnt   = kick_cnt_r;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// -----------------------------------------------------------------------------
// tb_watchdog_ctrl
//
// Directed scenarios with literal expectations, followed by a randomized run
// checked every cycle against a behavioural model of the watchdog rules.
// -----------------------------------------------------------------------------
module tb_watchdog_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] cfg_timeout;
  logic        cfg_load;
  logic        arm;
  logic        disarm;
  logic        clear;
  logic [1:0]  kick_req;
  logic [1:0]  kick_ack;
  logic        wd_active;
  logic        wd_expired;
  logic        wd_irq;
  logic [31:0] count;
  logic [15:0] kick_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int unsigned m_timeout, m_count, m_kick_cnt;
  bit          m_armed, m_expired, m_irq;
  int          m_last;   // requester served most recently

  watchdog_ctrl #(.CNT_WIDTH(32), .TIMEOUT_RST(1000)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_timeout(cfg_timeout), .cfg_load(cfg_load),
    .arm(arm), .disarm(disarm), .clear(clear), .kick_req(kick_req),
    .kick_ack(kick_ack), .wd_active(wd_active), .wd_expired(wd_expired),
    .wd_irq(wd_irq), .count(count), .kick_cnt(kick_cnt)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [1:0] model_ack();
    if (ARESET || !m_armed || disarm) return 2'b00;
    if (kick_req == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
    return kick_req;
  endfunction

  function automatic void model_update(input logic [1:0] g);
    bit irq_n;
    if (ARESET) begin
      m_timeout = 1000; m_count = 0; m_kick_cnt = 0;
      m_armed = 0; m_expired = 0; m_irq = 0; m_last = 1;
      return;
    end
    irq_n = 0;
    if (m_armed) begin
      if (disarm) begin
        m_armed = 0; m_count = 0;
      end else if (g != 2'b00) begin
        m_count = m_timeout;
        m_kick_cnt = (m_kick_cnt + 1) % 65536;
        m_last = g[0] ? 0 : 1;
      end else if (m_count == 1) begin
        m_armed = 0; m_expired = 1; m_count = 0; irq_n = 1;
      end else begin
        m_count = m_count - 1;
      end
    end else if (m_expired) begin
      if (clear) begin
        m_expired = 0; m_count = 0;
      end
    end else if (arm && m_timeout != 0) begin
      m_armed = 1; m_count = m_timeout; m_kick_cnt = 0;
    end
    if (cfg_load) m_timeout = cfg_timeout;
    m_irq = irq_n;
  endfunction

  // One clock: model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    logic [1:0] g;
    g = model_ack();
    @(posedge ACLK);
    model_update(g);
    #1;
  endtask

  task automatic load_timeout(input int unsigned v);
    cfg_timeout = v; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; arm = 1'b1; kick_req = 2'b11;
    #1;
    n_cmp++;
    if (kick_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", kick_ack); end
    tick(); tick();
    ARESET = 1'b0; arm = 1'b0; kick_req = 2'b00;
    n_cmp++;
    if ({wd_active, wd_expired, wd_irq} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {wd_active, wd_expired, wd_irq});
    end
    n_cmp++;
    if (count !== 32'd0 || kick_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got count=%0d kick_cnt=%0d want 0/0", count, kick_cnt);
    end
  endtask

  task automatic test_expiry();
    load_timeout(5);
    arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      arm = 1'b0;
      n_cmp++;
      if (count !== 32'(5 - i) || wd_active !== 1'b1) begin
        n_fail++; $display("FAIL expiry_count[%0d]: got count=%0d active=%b want %0d/1", i, count, wd_active, 5 - i);
      end
    end
    tick();
    n_cmp++;
    if ({wd_active, wd_expired, wd_irq} !== 3'b011 || count !== 32'd0) begin
      n_fail++; $display("FAIL expiry_entry: got flags=%b count=%0d want 011/0", {wd_active, wd_expired, wd_irq}, count);
    end
    tick();
    n_cmp++;
    if ({wd_expired, wd_irq} !== 2'b10) begin
      n_fail++; $display("FAIL expiry_irq_pulse: got exp/irq=%b want 10", {wd_expired, wd_irq});
    end
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++;
    if ({wd_active, wd_expired, wd_irq} !== 3'b000 || count !== 32'd0) begin
      n_fail++; $display("FAIL expiry_clear: got flags=%b count=%0d want 000/0", {wd_active, wd_expired, wd_irq}, count);
    end
  endtask

  task automatic test_kick_race();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (count !== 32'd1) begin n_fail++; $display("FAIL race_precount: got %0d want 1", count); end
    kick_req = 2'b01;
    #1;
    n_cmp++;
    if (kick_ack !== 2'b01) begin n_fail++; $display("FAIL race_ack: got %b want 01", kick_ack); end
    tick();
    kick_req = 2'b00;
    n_cmp++;
    if (count !== 32'd5 || wd_expired !== 1'b0 || wd_active !== 1'b1 || kick_cnt !== 16'd1) begin
      n_fail++; $display("FAIL race_reload: got count=%0d exp=%b act=%b kick_cnt=%0d want 5/0/1/1",
                         count, wd_expired, wd_active, kick_cnt);
    end
    disarm = 1'b1; tick(); disarm = 1'b0;
  endtask

  task automatic test_arbitration();
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    load_timeout(5);
    arm = 1'b1; tick(); arm = 1'b0;
    kick_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] want;
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_cmp++;
      if (kick_ack !== want) begin n_fail++; $display("FAIL arb_ack[%0d]: got %b want %b", i, kick_ack, want); end
      tick();
    end
    kick_req = 2'b00;
    n_cmp++;
    if (kick_cnt !== 16'd4 || count !== 32'd5) begin
      n_fail++; $display("FAIL arb_kick_cnt: got kick_cnt=%0d count=%0d want 4/5", kick_cnt, count);
    end
  endtask

  task automatic test_disarm_kick();
    disarm = 1'b1; kick_req = 2'b01;
    #1;
    n_cmp++;
    if (kick_ack !== 2'b00) begin n_fail++; $display("FAIL disarm_ack: got %b want 00", kick_ack); end
    tick();
    disarm = 1'b0;
    n_cmp++;
    if (wd_active !== 1'b0 || count !== 32'd0 || kick_cnt !== 16'd4) begin
      n_fail++; $display("FAIL disarm_state: got act=%b count=%0d kick_cnt=%0d want 0/0/4", wd_active, count, kick_cnt);
    end
    #1;
    n_cmp++;
    if (kick_ack !== 2'b00) begin n_fail++; $display("FAIL idle_pending_ack: got %b want 00", kick_ack); end
    kick_req = 2'b00;
    load_timeout(0);
    arm = 1'b1; tick(); arm = 1'b0;
    n_cmp++;
    if (wd_active !== 1'b0 || count !== 32'd0) begin
      n_fail++; $display("FAIL arm_zero: got act=%b count=%0d want 0/0", wd_active, count);
    end
  endtask

  task automatic test_expired();
    int k;
    load_timeout(8);
    arm = 1'b1; tick(); arm = 1'b0;
    k = 0;
    while (!wd_expired && k < 20) begin tick(); k++; end
    n_cmp++;
    if (wd_expired !== 1'b1 || k != 8) begin
      n_fail++; $display("FAIL exp_reach: got exp=%b after %0d cycles want 1 after 8", wd_expired, k);
    end
    arm = 1'b1; tick(); arm = 1'b0;
    disarm = 1'b1; tick(); disarm = 1'b0;
    n_cmp++;
    if ({wd_active, wd_expired} !== 2'b01) begin
      n_fail++; $display("FAIL exp_ignore_arm_disarm: got act/exp=%b want 01", {wd_active, wd_expired});
    end
    kick_req = 2'b01;
    #1;
    n_cmp++;
    if (kick_ack !== 2'b00) begin n_fail++; $display("FAIL exp_pending_ack: got %b want 00", kick_ack); end
    kick_req = 2'b00;
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++;
    if ({wd_active, wd_expired, wd_irq} !== 3'b000 || count !== 32'd0) begin
      n_fail++; $display("FAIL exp_clear: got flags=%b count=%0d want 000/0", {wd_active, wd_expired, wd_irq}, count);
    end
    arm = 1'b1; tick(); arm = 1'b0;
    load_timeout(3);
    n_cmp++;
    if (count !== 32'd7) begin n_fail++; $display("FAIL cfg_no_immediate: got %0d want 7", count); end
    kick_req = 2'b01; tick(); kick_req = 2'b00;
    n_cmp++;
    if (count !== 32'd3 || kick_cnt !== 16'd1) begin
      n_fail++; $display("FAIL cfg_next_reload: got count=%0d kick_cnt=%0d want 3/1", count, kick_cnt);
    end
    disarm = 1'b1; tick(); disarm = 1'b0;
    cfg_timeout = 6; cfg_load = 1'b1; arm = 1'b1; tick(); cfg_load = 1'b0; arm = 1'b0;
    n_cmp++;
    if (count !== 32'd3) begin n_fail++; $display("FAIL arm_with_load: got %0d want 3", count); end
    disarm = 1'b1; tick(); disarm = 1'b0;
  endtask

  task automatic test_reset_mid();
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (300) tick();
    n_cmp++;
    if (count !== 32'd700) begin n_fail++; $display("FAIL mid_precount: got %0d want 700", count); end
    ARESET = 1'b1; kick_req = 2'b01;
    #1;
    n_cmp++;
    if (kick_ack !== 2'b00) begin n_fail++; $display("FAIL mid_reset_ack: got %b want 00", kick_ack); end
    tick();
    ARESET = 1'b0; kick_req = 2'b00;
    n_cmp++;
    if ({wd_active, wd_expired, wd_irq} !== 3'b000 || count !== 32'd0 || kick_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_state: got flags=%b count=%0d kick_cnt=%0d want 000/0/0",
                         {wd_active, wd_expired, wd_irq}, count, kick_cnt);
    end
    arm = 1'b1; tick(); arm = 1'b0;
    n_cmp++;
    if (count !== 32'd1000) begin n_fail++; $display("FAIL mid_timeout_restored: got %0d want 1000", count); end
    disarm = 1'b1; tick(); disarm = 1'b0;
    load_timeout(1);
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    n_cmp++;
    if ({wd_expired, wd_irq} !== 2'b11) begin n_fail++; $display("FAIL t1_expire: got exp/irq=%b want 11", {wd_expired, wd_irq}); end
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    n_cmp++;
    if ({wd_active, wd_expired, wd_irq} !== 3'b000) begin
      n_fail++; $display("FAIL exp_reset: got flags=%b want 000", {wd_active, wd_expired, wd_irq});
    end
  endtask

  task automatic test_random();
    logic [1:0] prev_ack, want;
    prev_ack = 2'b00;
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ARESET      = ($urandom_range(0, 299) == 0);
      arm         = ($urandom_range(0, 3) == 0);
      disarm      = ($urandom_range(0, 15) == 0);
      clear       = ($urandom_range(0, 7) == 0);
      cfg_load    = ($urandom_range(0, 15) == 0);
      cfg_timeout = $urandom_range(1, 12);
      for (int r = 0; r < 2; r++) begin
        if (prev_ack[r]) kick_req[r] = 1'b0;
        else if (!kick_req[r]) kick_req[r] = ($urandom_range(0, 2) == 0);
      end
      #1;
      want = model_ack();
      n_cmp++;
      if (kick_ack !== want) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, kick_ack, want); end
      prev_ack = want;
      tick();
      n_cmp++;
      if (count !== 32'(m_count) || kick_cnt !== 16'(m_kick_cnt) ||
          {wd_active, wd_expired, wd_irq} !== {m_armed, m_expired, m_irq}) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: got count=%0d kick_cnt=%0d flags=%b want %0d/%0d/%b",
                 i, count, kick_cnt, {wd_active, wd_expired, wd_irq},
                 m_count, m_kick_cnt, {m_armed, m_expired, m_irq});
      end
    end
    ARESET = 1'b0; arm = 1'b0; disarm = 1'b0; clear = 1'b0; cfg_load = 1'b0; kick_req = 2'b00;
  endtask

  initial begin
    ARESET = 1'b1; cfg_timeout = 32'd0; cfg_load = 1'b0; arm = 1'b0;
    disarm = 1'b0; clear = 1'b0; kick_req = 2'b00;
    m_timeout = 1000; m_count = 0; m_kick_cnt = 0;
    m_armed = 0; m_expired = 0; m_irq = 0; m_last = 1;
    test_reset();
    test_expiry();
    test_kick_race();
    test_arbitration();
    test_disarm_kick();
    test_expired();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL time_limit: simulation did not finish within budget");
    $fatal(1, "time limit");
  end

endmodule
